// File: rtl/turtle_cpu_pkg.sv
`default_nettype none
// ============================================================================
// turtle_cpu_pkg : shared constants and types for the turtle CPU blocks
// Rev 1.0
// ============================================================================
package turtle_cpu_pkg;

  localparam int          DATA_WIDTH       = 8;
  localparam int          REGISTER_COUNT   = 16;
  localparam int          RF_ADDR_WIDTH    = $clog2(REGISTER_COUNT);
  localparam logic [7:0]  DUMP_HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    DS_IDLE     = 3'd0,
    DS_SEND_HDR = 3'd1,
    DS_FETCH    = 3'd2,
    DS_CAPTURE  = 3'd3,
    DS_SEND     = 3'd4,
    DS_SEND_SUM = 3'd5
  } dump_state_t;

  typedef enum logic {
    REGION_DMEM = 1'b0,
    REGION_RF   = 1'b1
  } dump_region_t;

endpackage
`default_nettype wire

// File: rtl/turtle_state_dumper_if.sv
`default_nettype none
// ============================================================================
// turtle_state_dumper_if : valid/ready byte stream out of the state dumper
// Rev 1.0
// ============================================================================
interface turtle_state_dumper_if;

  logic [turtle_cpu_pkg::DATA_WIDTH-1:0] tx_data;
  logic                                  tx_valid;
  logic                                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface
`default_nettype wire

// File: rtl/turtle_state_dumper.sv
`default_nettype none
// ============================================================================
// turtle_state_dumper : streams header, dmem, register file and checksum
// Rev 1.0
// ============================================================================
module turtle_state_dumper
  import turtle_cpu_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       start,
  output logic                            busy,
  output logic                            done,
  output logic [DMEM_ADDR_WIDTH-1:0]      dmem_rd_addr,
  input  wire logic [DATA_WIDTH-1:0]      dmem_rd_data,
  output logic [RF_ADDR_WIDTH-1:0]        rf_rd_addr,
  input  wire logic [DATA_WIDTH-1:0]      rf_rd_data,
  turtle_state_dumper_if.master           tx
);

  // Index must also be able to walk all register-file entries for narrow dmem.
  localparam int IDX_WIDTH = (DMEM_ADDR_WIDTH > RF_ADDR_WIDTH) ? DMEM_ADDR_WIDTH
                                                                : RF_ADDR_WIDTH;
  localparam logic [IDX_WIDTH-1:0] DMEM_LAST = IDX_WIDTH'({DMEM_ADDR_WIDTH{1'b1}});
  localparam logic [RF_ADDR_WIDTH-1:0] RF_LAST = {RF_ADDR_WIDTH{1'b1}};

  dump_state_t             state;
  dump_region_t            region;
  logic [IDX_WIDTH-1:0]    index;
  logic [DATA_WIDTH-1:0]   checksum;

  logic                    handshake;
  logic                    dmem_last;
  logic                    rf_last;
  logic [IDX_WIDTH-1:0]    index_next;
  logic [DATA_WIDTH-1:0]   rd_byte;

  assign handshake  = tx.tx_valid & tx.tx_ready;
  assign dmem_last  = (index == DMEM_LAST);
  assign rf_last    = (index[RF_ADDR_WIDTH-1:0] == RF_LAST);
  assign index_next = index + 1'b1;
  assign rd_byte    = (region == REGION_RF) ? rf_rd_data : dmem_rd_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= DS_IDLE;
      region       <= REGION_DMEM;
      index        <= '0;
      checksum     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tx.tx_data   <= '0;
      tx.tx_valid  <= 1'b0;
      dmem_rd_addr <= '0;
      rf_rd_addr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        DS_IDLE: begin
          if (start) begin
            state        <= DS_SEND_HDR;
            region       <= REGION_DMEM;
            index        <= '0;
            checksum     <= '0;
            busy         <= 1'b1;
            tx.tx_data   <= DUMP_HEADER_BYTE;
            tx.tx_valid  <= 1'b1;
            dmem_rd_addr <= '0;
            rf_rd_addr   <= '0;
          end
        end

        DS_SEND_HDR: begin
          if (handshake) begin
            tx.tx_valid <= 1'b0;
            state       <= DS_FETCH;
          end
        end

        // Address was registered on entry; the read port answers next cycle.
        DS_FETCH: begin
          state <= DS_CAPTURE;
        end

        DS_CAPTURE: begin
          tx.tx_data  <= rd_byte;
          tx.tx_valid <= 1'b1;
          checksum    <= checksum + rd_byte;
          state       <= DS_SEND;
        end

        DS_SEND: begin
          if (handshake) begin
            tx.tx_valid <= 1'b0;
            if ((region == REGION_DMEM) && dmem_last) begin
              region       <= REGION_RF;
              index        <= '0;
              dmem_rd_addr <= '0;
              rf_rd_addr   <= '0;
              state        <= DS_FETCH;
            end else if ((region == REGION_RF) && rf_last) begin
              tx.tx_data  <= checksum;
              tx.tx_valid <= 1'b1;
              state       <= DS_SEND_SUM;
            end else begin
              index <= index_next;
              if (region == REGION_DMEM) begin
                dmem_rd_addr <= index_next[DMEM_ADDR_WIDTH-1:0];
              end else begin
                rf_rd_addr <= index_next[RF_ADDR_WIDTH-1:0];
              end
              state <= DS_FETCH;
            end
          end
        end

        DS_SEND_SUM: begin
          if (handshake) begin
            tx.tx_valid <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DS_IDLE;
          end
        end

        default: begin
          state <= DS_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_turtle_state_dumper.sv
`default_nettype none
// ============================================================================
// tb_turtle_state_dumper : directed self-checking bench, DMEM_ADDR_WIDTH = 2
// Rev 1.0
// ============================================================================
module tb_turtle_state_dumper;
  import turtle_cpu_pkg::*;

  localparam int W            = 2;
  localparam int DMEM_SIZE    = 1 << W;
  localparam int FRAME_LEN    = DMEM_SIZE + 18;
  localparam int FRAME_CYCLES = 3 * (DMEM_SIZE + 16) + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] dmem_rd_addr;
  logic [7:0]   dmem_rd_data;
  logic [3:0]   rf_rd_addr;
  logic [7:0]   rf_rd_data;

  turtle_state_dumper_if tx_if ();

  turtle_state_dumper #(.DMEM_ADDR_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .dmem_rd_addr (dmem_rd_addr),
    .dmem_rd_data (dmem_rd_data),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .tx           (tx_if.master)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory models, one cycle of latency.
  logic [7:0] dmem [DMEM_SIZE];
  logic [7:0] rf   [16];
  always @(posedge clk) begin
    dmem_rd_data <= dmem[dmem_rd_addr];
    rf_rd_data   <= rf[rf_rd_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ready driver
  logic rand_mode   = 1'b0;
  logic ready_fixed = 1'b1;
  always begin
    @(posedge clk);
    #1;
    tx_if.tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  // Stream monitor
  logic [7:0] rx_q [$];
  int         done_cnt   = 0;
  time        done_time  = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'b0, tx_if.tx_valid}, 32'd1);
        check("stall_data", {24'b0, tx_if.tx_data}, {24'b0, prev_data});
      end
      if (tx_if.tx_valid && tx_if.tx_ready) rx_q.push_back(tx_if.tx_data);
      if (done) begin
        done_cnt++;
        done_time = $time;
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
    end
  end

  time start_time;

  task automatic compare_frame(input string tag);
    logic [7:0]  exp_q [$];
    logic [7:0]  sum;
    logic [31:0] got;
    sum = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < DMEM_SIZE; i++) begin
      exp_q.push_back(dmem[i]);
      sum = sum + dmem[i];
    end
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(rf[i]);
      sum = sum + rf[i];
    end
    exp_q.push_back(sum);
    check({tag, ".len"}, rx_q.size(), FRAME_LEN);
    for (int i = 0; i < FRAME_LEN; i++) begin
      got = (i < rx_q.size()) ? {24'b0, rx_q[i]} : 32'hFFFF_FFFF;
      check($sformatf("%s.byte%0d", tag, i), got, {24'b0, exp_q[i]});
    end
  endtask

  task automatic run_frame(input string tag, input bit check_timing, input bit late_start);
    rx_q.delete();
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk);
    start_time = $time;
    #1 start = 1'b0;
    check({tag, ".hdr_valid"}, {31'b0, tx_if.tx_valid}, 32'd1);
    check({tag, ".hdr_data"}, {24'b0, tx_if.tx_data}, 32'hA5);
    check({tag, ".busy"}, {31'b0, busy}, 32'd1);
    if (late_start) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge clk);
    check({tag, ".done_seen"}, done_cnt, 32'd1);
    if (check_timing)
      check({tag, ".cycles"}, 32'((done_time - start_time - 5) / 10), FRAME_CYCLES);
    repeat (100) @(negedge clk);
    check({tag, ".done_once"}, done_cnt, 32'd1);
    check({tag, ".busy_after"}, {31'b0, busy}, 32'd0);
    compare_frame(tag);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < DMEM_SIZE; i++) dmem[i] = 8'(i + 1);
    for (int i = 0; i < 16; i++) rf[i] = 8'(8'h10 + i);
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.valid", {31'b0, tx_if.tx_valid}, 32'd0);
    check("rst.data", {24'b0, tx_if.tx_data}, 32'h00);
    check("rst.dmem_addr", {30'b0, dmem_rd_addr}, 32'd0);
    check("rst.rf_addr", {28'b0, rf_rd_addr}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // Basic frame, full-rate; checksum 0x0A + 0x178 = 0x182 -> 0x82
    run_frame("basic", 1'b1, 1'b0);
    check("basic.sum_hand", (rx_q.size() == FRAME_LEN) ? {24'b0, rx_q[FRAME_LEN-1]} : 32'hFFFF_FFFF, 32'h82);

    // Back-pressured frame
    rand_mode = 1'b1;
    run_frame("backpr", 1'b0, 1'b0);
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);

    // All ones: 20 * 0xFF mod 256 = 0xEC
    for (int i = 0; i < DMEM_SIZE; i++) dmem[i] = 8'hFF;
    for (int i = 0; i < 16; i++) rf[i] = 8'hFF;
    run_frame("allff", 1'b1, 1'b0);
    check("allff.sum_hand", (rx_q.size() == FRAME_LEN) ? {24'b0, rx_q[FRAME_LEN-1]} : 32'hFFFF_FFFF, 32'hEC);

    // Start while busy is ignored
    for (int i = 0; i < DMEM_SIZE; i++) dmem[i] = 8'(8'h30 + 7 * i);
    for (int i = 0; i < 16; i++) rf[i] = 8'(8'hC0 ^ i);
    run_frame("restart", 1'b1, 1'b1);

    // Reset while the third payload byte is stalled on the stream
    rx_q.delete();
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 200 && rx_q.size() < 3; i++) @(negedge clk);
    ready_fixed = 1'b0;
    for (int i = 0; i < 200 && !tx_if.tx_valid; i++) @(negedge clk);
    check("midrst.pre_valid", {31'b0, tx_if.tx_valid}, 32'd1);
    check("midrst.pre_data", {24'b0, tx_if.tx_data}, {24'b0, dmem[2]});
    reset = 1'b1;
    #1;
    check("midrst.valid", {31'b0, tx_if.tx_valid}, 32'd0);
    check("midrst.busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    ready_fixed = 1'b1;
    @(negedge clk) reset = 1'b0;
    run_frame("after_rst", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
